// File: rtl/sampler_scheduler_pkg.sv
// Shared definitions for the sampler voice scheduler.
// Holds the scheduler FSM state enum, the bit layout of the tuser sideband,
// the reserved all-ones tuser value that marks a stop beat, and a small
// helper that converts a loop index into a voice-index field.
package sampler_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_STREAM = 2'd2,
    ST_STOP   = 2'd3
  } sched_state_t;

  // tuser layout during STREAM: {0..., is_last, voice_index[5:0]}
  localparam int LAST_STREAM_BIT = 6;
  localparam int VOICE_IDX_LSB   = 0;
  localparam int VOICE_IDX_WIDTH = 6;

  // Stop-beat marker; sliced down to the actual tuser width at the top level.
  localparam int                          STOP_TUSER_MAX_W = 64;
  localparam logic [STOP_TUSER_MAX_W-1:0] STOP_TUSER       = '1;

  function automatic logic [VOICE_IDX_WIDTH-1:0] voice_idx(input int i);
    return VOICE_IDX_WIDTH'(i);
  endfunction

endpackage

// File: rtl/sampler_voice_select.sv
// Lowest-set-bit priority encoder used to pick the next voice of a block.
// Ports:
//   mask      - voices still waiting to be streamed in the current block
//   index     - position of the lowest set bit of mask (0 when mask is empty)
//   found     - mask has at least one bit set
//   remaining - mask with its lowest set bit cleared
module sampler_voice_select
  import sampler_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 8
) (
  input  logic [NUM_VOICES-1:0]      mask,
  output logic [VOICE_IDX_WIDTH-1:0] index,
  output logic                       found,
  output logic [NUM_VOICES-1:0]      remaining
);

  // Scan from the top down so the last match written is the lowest bit.
  always_comb begin
    index = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = voice_idx(i);
      end
    end
  end

  assign found = |mask;

  // x & (x - 1) clears exactly the lowest set bit.
  assign remaining = mask & (mask - NUM_VOICES'(1));

endmodule

// File: rtl/sampler_voice_scheduler.sv
// Sampler voice scheduler: streams one block of BLOCK_LEN samples from each
// enabled voice, lowest voice first, onto a single AXI-Stream towards the
// mixer, and can flush the mixer with a dedicated stop beat.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   voice_enable          - per-voice active mask, snapshotted at block_start
//   block_start           - one-cycle request to schedule one block
//   stop_req              - one-cycle request to emit a stop beat
//   voice_tdata/tvalid    - per-voice sample sources, voice i at slice i
//   voice_tready          - per-voice ready, only the streaming voice sees tready
//   axi_stream_master_*   - AXI-Stream to the mixer
//   busy                  - scheduler is not idle
//   block_done            - one-cycle pulse when a block or stop completes
//   overrun               - one-cycle pulse when block_start arrives while busy
module sampler_voice_scheduler
  import sampler_scheduler_pkg::*;
#(
  parameter int NUM_VOICES               = 8,
  parameter int C_AXI_STREAM_TDATA_WIDTH = 32,
  parameter int C_AXI_STREAM_TUSER_WIDTH = 32,
  parameter int BLOCK_LEN                = 64
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_VOICES-1:0]                          voice_enable,
  input  logic                                           block_start,
  input  logic                                           stop_req,
  input  logic [NUM_VOICES*C_AXI_STREAM_TDATA_WIDTH-1:0] voice_tdata,
  input  logic [NUM_VOICES-1:0]                          voice_tvalid,
  output logic [NUM_VOICES-1:0]                          voice_tready,
  output logic [C_AXI_STREAM_TDATA_WIDTH-1:0]            axi_stream_master_tdata,
  output logic                                           axi_stream_master_tvalid,
  output logic                                           axi_stream_master_tlast,
  output logic [C_AXI_STREAM_TUSER_WIDTH-1:0]            axi_stream_master_tuser,
  input  logic                                           axi_stream_master_tready,
  output logic                                           busy,
  output logic                                           block_done,
  output logic                                           overrun
);

  localparam int TDW   = C_AXI_STREAM_TDATA_WIDTH;
  localparam int TUW   = C_AXI_STREAM_TUSER_WIDTH;
  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  sched_state_t state;
  sched_state_t state_next;

  logic [NUM_VOICES-1:0]      remaining_mask;
  logic [VOICE_IDX_WIDTH-1:0] cur_voice;
  logic [CNT_W-1:0]           sample_cnt;
  logic                       is_last;
  logic                       stop_pending;

  logic [VOICE_IDX_WIDTH-1:0] sel_index;
  logic                       sel_found;
  logic [NUM_VOICES-1:0]      sel_remaining;

  logic                       cur_tvalid;
  logic [TDW-1:0]             cur_tdata;
  logic                       beat_last;
  logic                       stream_hs;
  logic                       stop_hs;
  logic                       stop_active;

  sampler_voice_select #(
    .NUM_VOICES (NUM_VOICES)
  ) u_select (
    .mask      (remaining_mask),
    .index     (sel_index),
    .found     (sel_found),
    .remaining (sel_remaining)
  );

  // Route the currently selected voice's source onto the internal beat.
  always_comb begin
    cur_tvalid = 1'b0;
    cur_tdata  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (cur_voice == voice_idx(i)) begin
        cur_tvalid = voice_tvalid[i];
        cur_tdata  = voice_tdata[i*TDW +: TDW];
      end
    end
  end

  assign beat_last   = (sample_cnt == CNT_W'(BLOCK_LEN - 1));
  assign stream_hs   = (state == ST_STREAM) && cur_tvalid && axi_stream_master_tready;
  assign stop_hs     = (state == ST_STOP) && axi_stream_master_tready;
  // A stop seen this cycle acts at once; one seen earlier waits in stop_pending.
  assign stop_active = stop_req || stop_pending;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (stop_req) begin
          state_next = ST_STOP;
        end else if (block_start && (|voice_enable)) begin
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (stop_req) begin
          state_next = ST_STOP;
        end else if (sel_found) begin
          state_next = ST_STREAM;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // A beat already offered is never withdrawn: leave for STOP only
        // when nothing is offered or the offered beat has just been taken.
        if (stop_active && (!cur_tvalid || stream_hs)) begin
          state_next = ST_STOP;
        end else if (stream_hs && beat_last) begin
          state_next = is_last ? ST_IDLE : ST_SELECT;
        end
      end
      ST_STOP: begin
        if (axi_stream_master_tready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Block bookkeeping and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_mask <= '0;
      cur_voice      <= '0;
      sample_cnt     <= '0;
      is_last        <= 1'b0;
      stop_pending   <= 1'b0;
      block_done     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      block_done <= 1'b0;
      overrun    <= block_start && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (block_start && !stop_req) begin
            remaining_mask <= voice_enable;
            // An empty block completes immediately without leaving IDLE.
            if (voice_enable == '0) begin
              block_done <= 1'b1;
            end
          end
        end
        ST_SELECT: begin
          if (!stop_req) begin
            cur_voice      <= sel_index;
            remaining_mask <= sel_remaining;
            is_last        <= (sel_remaining == '0);
            sample_cnt     <= '0;
            if (!sel_found) begin
              block_done <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (stop_req) begin
            stop_pending <= 1'b1;
          end
          if (stream_hs) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
          end
          if (stream_hs && beat_last && is_last && !stop_active) begin
            block_done <= 1'b1;
          end
        end
        ST_STOP: begin
          if (stop_hs) begin
            block_done     <= 1'b1;
            remaining_mask <= '0;
            stop_pending   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: zero-latency forwarding in STREAM, fixed stop beat in STOP
  always_comb begin
    axi_stream_master_tdata  = '0;
    axi_stream_master_tvalid = 1'b0;
    axi_stream_master_tlast  = 1'b0;
    axi_stream_master_tuser  = '0;
    voice_tready             = '0;
    busy                     = (state != ST_IDLE);
    case (state)
      ST_STREAM: begin
        axi_stream_master_tdata  = cur_tdata;
        axi_stream_master_tvalid = cur_tvalid;
        axi_stream_master_tlast  = beat_last;
        axi_stream_master_tuser[VOICE_IDX_LSB +: VOICE_IDX_WIDTH] = cur_voice;
        axi_stream_master_tuser[LAST_STREAM_BIT]                  = is_last;
        for (int i = 0; i < NUM_VOICES; i++) begin
          voice_tready[i] = (cur_voice == voice_idx(i)) && axi_stream_master_tready;
        end
      end
      ST_STOP: begin
        axi_stream_master_tvalid = 1'b1;
        axi_stream_master_tlast  = 1'b1;
        axi_stream_master_tuser  = STOP_TUSER[TUW-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sampler_voice_scheduler.sv
// Testbench for sampler_voice_scheduler. A queue of expected output beats is
// built from the block rules (ascending voices, BLOCK_LEN beats each, stop
// beat on request) and compared with the DUT every cycle; the voice sources
// are randomised AXI-Stream masters that hold each beat until it is taken.
module tb_sampler_voice_scheduler;

  localparam int NV  = 8;
  localparam int TDW = 32;
  localparam int TUW = 32;
  localparam int BL  = 64;

  typedef struct {
    int          voice;
    int          idx;
    logic [31:0] tuser;
    logic        tlast;
    logic        done;
    logic        stop;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NV-1:0]     voice_enable;
  logic              block_start;
  logic              stop_req;
  logic [NV*TDW-1:0] voice_tdata;
  logic [NV-1:0]     voice_tvalid;
  logic [NV-1:0]     voice_tready;
  logic [TDW-1:0]    m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic [TUW-1:0]    m_tuser;
  logic              m_tready;
  logic              busy;
  logic              block_done;
  logic              overrun;

  always #5 clk = ~clk;

  sampler_voice_scheduler #(
    .NUM_VOICES               (NV),
    .C_AXI_STREAM_TDATA_WIDTH (TDW),
    .C_AXI_STREAM_TUSER_WIDTH (TUW),
    .BLOCK_LEN                (BL)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .voice_enable             (voice_enable),
    .block_start              (block_start),
    .stop_req                 (stop_req),
    .voice_tdata              (voice_tdata),
    .voice_tvalid             (voice_tvalid),
    .voice_tready             (voice_tready),
    .axi_stream_master_tdata  (m_tdata),
    .axi_stream_master_tvalid (m_tvalid),
    .axi_stream_master_tlast  (m_tlast),
    .axi_stream_master_tuser  (m_tuser),
    .axi_stream_master_tready (m_tready),
    .busy                     (busy),
    .block_done               (block_done),
    .overrun                  (overrun)
  );

  beat_t       q[$];
  logic        src_valid [NV];
  int          src_cnt   [NV];
  int          mcnt      [NV];
  logic        in_select;
  logic        exp_done;
  logic        exp_ovr;
  logic        check_en;
  logic        force_stall;
  int unsigned rdy_pct;
  int unsigned val_pct;
  int          checks;
  int          errors;
  int          n_beats, n_tlast, n_stop, n_done, n_ovr;

  function automatic logic [31:0] sample_of(input int v, input int k);
    return {8'(v), 8'(k), 16'(k * 37 + v * 101)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one block: each enabled voice in ascending order,
  // BL beats per voice, is_last flag on every beat of the highest voice.
  task automatic push_block(input logic [NV-1:0] mask);
    int    hv;
    beat_t b;
    hv = 0;
    for (int v = 0; v < NV; v++) if (mask[v]) hv = v;
    for (int v = 0; v < NV; v++) begin
      if (mask[v]) begin
        for (int k = 0; k < BL; k++) begin
          b.voice = v;
          b.idx   = k;
          b.tuser = 32'(v);
          b.tuser[6] = (v == hv);
          b.tlast = (k == BL - 1);
          b.done  = (v == hv) && (k == BL - 1);
          b.stop  = 1'b0;
          q.push_back(b);
        end
      end
    end
  endtask

  task automatic push_stop();
    beat_t b;
    b.voice = 0;
    b.idx   = 0;
    b.tuser = '1;
    b.tlast = 1'b1;
    b.done  = 1'b1;
    b.stop  = 1'b1;
    q.push_back(b);
  endtask

  task automatic clear_tally();
    n_beats = 0; n_tlast = 0; n_stop = 0; n_done = 0; n_ovr = 0;
  endtask

  // One clock cycle: drive sources, check DUT against the model, advance model.
  task automatic step();
    beat_t         f;
    logic          act, exp_v, hs_m, busy_now, pend, data_chk, sel_n;
    logic [31:0]   exp_d, exp_u;
    logic          exp_l;
    logic [NV-1:0] exp_rdy;

    for (int v = 0; v < NV; v++) begin
      if (!src_valid[v]) src_valid[v] = ($urandom_range(99) < val_pct);
      voice_tvalid[v]          = src_valid[v];
      voice_tdata[v*TDW +: TDW] = sample_of(v, src_cnt[v]);
    end
    m_tready = ($urandom_range(99) < rdy_pct) && !force_stall && !reset;
    #3;

    act = (q.size() != 0) && !in_select;
    exp_v = 1'b0; exp_d = '0; exp_u = '0; exp_l = 1'b0; exp_rdy = '0;
    if (act) begin
      f = q[0];
      if (f.stop) begin
        exp_v = 1'b1; exp_u = '1; exp_l = 1'b1;
      end else begin
        exp_v   = src_valid[f.voice];
        exp_d   = sample_of(f.voice, mcnt[f.voice]);
        exp_u   = f.tuser;
        exp_l   = f.tlast;
        exp_rdy = m_tready ? (NV'(1) << f.voice) : '0;
      end
    end
    data_chk = !act || exp_v;

    if (check_en) begin
      chk("busy",         64'(busy),         64'(q.size() != 0));
      chk("block_done",   64'(block_done),   64'(exp_done));
      chk("overrun",      64'(overrun),      64'(exp_ovr));
      chk("tvalid",       64'(m_tvalid),     64'(exp_v));
      chk("voice_tready", 64'(voice_tready), 64'(exp_rdy));
      if (data_chk) begin
        chk("tdata", 64'(m_tdata), 64'(exp_d));
        chk("tuser", 64'(m_tuser), 64'(exp_u));
        chk("tlast", 64'(m_tlast), 64'(exp_l));
      end
    end

    if (m_tvalid === 1'b1 && m_tready) begin
      n_beats++;
      if (m_tlast === 1'b1) n_tlast++;
      if (m_tuser === '1) n_stop++;
    end
    if (block_done === 1'b1) n_done++;
    if (overrun === 1'b1) n_ovr++;

    for (int v = 0; v < NV; v++) begin
      if (voice_tvalid[v] && (voice_tready[v] === 1'b1)) begin
        src_cnt[v]++;
        src_valid[v] = 1'b0;
      end
    end

    hs_m     = exp_v && m_tready;
    busy_now = (q.size() != 0);
    exp_done = 1'b0;
    exp_ovr  = 1'b0;
    sel_n    = 1'b0;
    if (reset) begin
      q.delete();
    end else begin
      if (hs_m) begin
        f = q.pop_front();
        if (!f.stop) mcnt[f.voice]++;
        if (f.done) exp_done = 1'b1;
        if (!f.stop && f.tlast && !f.done) sel_n = 1'b1;
      end
      if (block_start && busy_now) exp_ovr = 1'b1;
      if (stop_req) begin
        // An offered but untaken beat survives the stop; the rest is flushed.
        pend = exp_v && !m_tready;
        if (pend) begin
          f = q[0];
          q.delete();
          q.push_back(f);
        end else begin
          q.delete();
        end
        push_stop();
        sel_n = 1'b0;
      end else if (block_start && !busy_now) begin
        if (voice_enable == '0) exp_done = 1'b1;
        else begin
          push_block(voice_enable);
          sel_n = 1'b1;
        end
      end
    end
    in_select = sel_n;

    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [NV-1:0] en);
    voice_enable = en;
    block_start  = 1'b1;
    step();
    block_start  = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while ((q.size() != 0 || exp_done || exp_ovr) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 64'(n >= maxc), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic elig;
    checks = 0; errors = 0;
    clear_tally();
    for (int v = 0; v < NV; v++) begin
      src_valid[v] = 1'b0; src_cnt[v] = 0; mcnt[v] = 0;
    end
    in_select = 1'b0; exp_done = 1'b0; exp_ovr = 1'b0;
    force_stall = 1'b0; rdy_pct = 100; val_pct = 100;
    reset = 1'b1; voice_enable = '0; block_start = 1'b0; stop_req = 1'b0;
    voice_tdata = '0; voice_tvalid = '0; m_tready = 1'b0;

    // Reset: first edge brings the DUT out of X, then reset state is checked.
    check_en = 1'b0;
    step();
    check_en = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Two voices (0 and 2), always ready.
    clear_tally();
    pulse_start(8'b0000_0101);
    run_until_idle("req036_timeout", 400);
    chk("req036_beats", 64'(n_beats), 64'(128));
    chk("req036_tlast", 64'(n_tlast), 64'(2));
    chk("req036_done",  64'(n_done),  64'(1));

    // Single highest voice.
    clear_tally();
    pulse_start(8'b1000_0000);
    run_until_idle("req037_timeout", 200);
    chk("req037_beats", 64'(n_beats), 64'(64));
    chk("req037_tlast", 64'(n_tlast), 64'(1));
    chk("req037_done",  64'(n_done),  64'(1));

    // Empty block.
    clear_tally();
    pulse_start('0);
    run_until_idle("req038_timeout", 10);
    step();
    chk("req038_beats", 64'(n_beats), 64'(0));
    chk("req038_done",  64'(n_done),  64'(1));

    // Stop while beat 10 of voice 0 is stalled for 3 cycles.
    clear_tally();
    pulse_start(8'b0000_0001);
    n = 0;
    while (!(q.size() != 0 && !in_select && !q[0].stop && q[0].idx == 9) && n < 200) begin
      step();
      n++;
    end
    chk("req039_reach", 64'(n >= 200), 64'(0));
    force_stall = 1'b1;
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    step();
    step();
    force_stall = 1'b0;
    run_until_idle("req039_timeout", 50);
    chk("req039_beats", 64'(n_beats), 64'(11));
    chk("req039_stop",  64'(n_stop),  64'(1));
    chk("req039_done",  64'(n_done),  64'(1));

    // block_start while busy, then stop and start together while idle.
    clear_tally();
    pulse_start(8'b0000_0011);
    for (int i = 0; i < 20; i++) step();
    pulse_start(8'b1111_1111);
    run_until_idle("req040_timeout", 400);
    chk("req040_beats", 64'(n_beats), 64'(128));
    chk("req040_ovr",   64'(n_ovr),   64'(1));
    clear_tally();
    block_start = 1'b1;
    stop_req    = 1'b1;
    voice_enable = 8'b0000_0001;
    step();
    block_start = 1'b0;
    stop_req    = 1'b0;
    run_until_idle("req040b_timeout", 20);
    chk("req040b_beats", 64'(n_beats), 64'(1));
    chk("req040b_stop",  64'(n_stop),  64'(1));
    chk("req040b_ovr",   64'(n_ovr),   64'(0));

    // Reset mid-stream, then a fresh block with random stalls.
    rdy_pct = 60; val_pct = 60;
    pulse_start(8'b0000_1111);
    for (int i = 0; i < 30; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    clear_tally();
    pulse_start(8'b0000_0010);
    run_until_idle("req041_timeout", 1000);
    chk("req041_beats", 64'(n_beats), 64'(64));
    chk("req041_stop",  64'(n_stop),  64'(0));
    chk("req041_done",  64'(n_done),  64'(1));

    // Random blocks with stalls, stray block_start, mid-voice stops and
    // voice_enable changing after the snapshot.
    rdy_pct = 65; val_pct = 70;
    for (int blk = 0; blk < 10; blk++) begin
      pulse_start(NV'($urandom_range(255)));
      n = 0;
      while ((q.size() != 0 || exp_done || exp_ovr) && n < 4000) begin
        voice_enable = NV'($urandom_range(255));
        block_start  = ($urandom_range(199) == 0);
        elig = (q.size() != 0) && !in_select && !q[0].stop &&
               (q[0].idx >= 1) && (q[0].idx <= 60);
        stop_req = elig && ($urandom_range(499) == 0);
        step();
        block_start = 1'b0;
        stop_req    = 1'b0;
        n++;
      end
      chk("rand_timeout", 64'(n >= 4000), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sampler_voice_scheduler.md
SAMPLER_VOICE_SCHEDULER -- requirements
Module: sampler_voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 8: number of voice requesters, range 1..32.
REQ-002 Parameter C_AXI_STREAM_TDATA_WIDTH, default 32: sample width, {right[31:16], left[15:0]}.
REQ-003 Parameter C_AXI_STREAM_TUSER_WIDTH, default 32: tuser width.
REQ-004 Parameter BLOCK_LEN, default 64: samples per voice stream.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 voice_enable  in  NUM_VOICES  per-voice active mask.
REQ-008 block_start  in  1  one-cycle request to schedule one block.
REQ-009 stop_req  in  1  one-cycle request to flush the downstream mixer.
REQ-010 voice_tdata  in  NUM_VOICES*TDATA_WIDTH  per-voice sample data, voice i at slice i.
REQ-011 voice_tvalid  in  NUM_VOICES  per-voice valid.
REQ-012 voice_tready  out  NUM_VOICES  per-voice ready.
REQ-013 axi_stream_master_tdata/tvalid/tlast/tuser/tready  out/out/out/out/in  TDATA/1/1/TUSER/1  AXI-Stream to the mixer.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 block_done  out  1  one-cycle pulse when a block or stop completes.
REQ-016 overrun  out  1  one-cycle pulse when block_start arrives while busy.

Function
REQ-017 FSM states are IDLE, SELECT, STREAM and STOP.
REQ-018 IDLE, block_start=1, stop_req=0: snapshot voice_enable into remaining_mask and go to SELECT.
- If the snapshot is all zeros, pulse block_done next cycle, emit no beats and stay in IDLE.
REQ-019 SELECT (one cycle): pick the lowest set bit of remaining_mask as cur_voice and clear it.
- is_last = (remaining_mask after clearing == 0).
- Reset sample_cnt to 0 and go to STREAM.
REQ-020 STREAM forwards combinationally, zero latency:
- master_tdata = voice_tdata[cur_voice].
- master_tvalid = voice_tvalid[cur_voice].
- voice_tready[cur_voice] = master_tready; all other voice_tready = 0.
REQ-021 STREAM sideband:
- tlast = (sample_cnt == BLOCK_LEN-1).
- tuser[5:0] = cur_voice, tuser[6] = is_last, other tuser bits 0.
REQ-022 sample_cnt increments on each beat with tvalid && tready.
- On the tlast handshake: if is_last, pulse block_done and go to IDLE; else go to SELECT.
REQ-023 A tuser value of all ones is reserved for the stop beat and is never produced in STREAM.
REQ-024 stop_req in IDLE goes to STOP. stop_req has priority over a simultaneous block_start, which is dropped without an overrun pulse.
REQ-025 stop_req in SELECT goes to STOP.
REQ-026 stop_req in STREAM is latched as stop_pending:
- If no beat is outstanding (tvalid=0), go to STOP next cycle.
- Otherwise go to STOP after the current beat's handshake.
- Never withdraw a beat whose tvalid is already asserted.
REQ-027 STOP drives one beat: tvalid=1, tdata=0, tlast=1, tuser all ones, all voice_tready=0.
- On handshake: pulse block_done, clear remaining_mask and stop_pending, go to IDLE.
REQ-028 block_start while busy pulses overrun and is otherwise ignored.
REQ-029 voice_enable changes after the snapshot do not affect the block in progress.
REQ-030 Outside STREAM and STOP, master_tvalid, tlast, tdata and tuser are 0, and all voice_tready are 0.
REQ-031 master_tvalid never depends combinationally on master_tready.

Reset
REQ-032 On reset=1 at a clock edge:
- State = IDLE; remaining_mask, cur_voice, sample_cnt, is_last and stop_pending = 0.
- block_done and overrun = 0; all AXIS outputs and voice_tready = 0.
REQ-033 Reset mid-STREAM abandons the block immediately, emitting no further beats and no stop beat.

Structure
REQ-034 Package sampler_scheduler_pkg holds:
- the FSM state enum;
- LAST_STREAM_BIT = 6, VOICE_IDX_LSB = 0, VOICE_IDX_WIDTH = 6;
- the STOP_TUSER all-ones constant.
REQ-035 Sub-module sampler_voice_select: combinational lowest-set-bit priority encoder.
- Inputs: mask. Outputs: index, found, remaining-after-clear.

Verification
REQ-036 enable=8'b0000_0101, block_start, tready=1 -> 64 beats with tuser=0x00 then 64 beats with tuser=0x42; tlast on beats 64 and 128; one block_done pulse.
REQ-037 enable=8'b1000_0000 -> 64 beats, tuser=0x47, tlast on beat 64, block_done.
REQ-038 enable=0, block_start -> no tvalid, block_done pulse one cycle later, busy stays 0.
REQ-039 stop_req during beat 10 of voice 0, with tready held low for 3 cycles -> beat 10 completes unchanged, then one beat with tuser=0xFFFFFFFF, tlast=1, tdata=0; state returns to IDLE.
REQ-040 block_start while busy -> overrun pulse, no change to the beat sequence; block_start and stop_req together in IDLE -> stop beat only.
REQ-041 reset asserted mid-STREAM, then enable=8'b0000_0010 and block_start -> fresh block of 64 beats with tuser=0x41; random tready/tvalid stalls keep every beat stable until its handshake.
